// File: rtl/key_matrix_scan_pkg.sv
// Shared keypad/display constants, FSM state encoding and small map helpers
// used by the keypad scanner and its debounce stage.
package key_matrix_scan_pkg;

    localparam logic [15:0] SCAN_MAX_DEF   = 16'd49_999;
    localparam logic [3:0]  DEB_FRAMES_DEF = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_MULTI = 2'd2
    } kms_state_t;

    function automatic logic is_onehot16(input logic [15:0] m);
        return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
    endfunction

    // Only meaningful for a one-hot map; returns the position of the set bit.
    function automatic logic [3:0] onehot_idx16(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_matrix_scan_debounce.sv
// Whole-keypad debounce: a frame is accepted once DEB_FRAMES consecutive
// identical frames have been seen; the accepted map is held until the next one.
module key_frame_debounce
    import key_matrix_scan_pkg::*;
#(
    parameter logic [3:0] DEB_FRAMES = DEB_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_done,
    input  logic [15:0] i_frame,
    output logic [15:0] o_key_map
);

    localparam logic [3:0] DEB_LAST = DEB_FRAMES - 4'd1;

    logic [15:0] r_cand;
    logic [3:0]  r_deb_cnt;
    logic [15:0] r_key_map;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand    <= 16'd0;
            r_deb_cnt <= 4'd0;
        end else if (i_frame_done) begin
            if (i_frame == r_cand) begin
                if (r_deb_cnt != DEB_LAST) begin
                    r_deb_cnt <= r_deb_cnt + 4'd1;
                end
            end else begin
                r_cand    <= i_frame;
                r_deb_cnt <= 4'd0;
            end
        end
    end

    // Re-writing the same cand while saturated is harmless and keeps this a plain compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_map <= 16'd0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_key_map <= r_cand;
        end
    end

    assign o_key_map = r_key_map;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: walks an active-low row strobe with 1 ms slots, samples
// the synchronized columns into a frame, debounces it and reports single keys.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_MAX   = SCAN_MAX_DEF,
    parameter logic [3:0]  DEB_FRAMES = DEB_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] key_map
);

    // Synchronizer stores the inverted columns so its cleared state means "nothing pressed".
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [15:0] r_cnt_slot;
    logic [1:0]  r_row_idx;
    logic [3:0]  r_row;
    logic [15:0] r_frame_buf;
    logic        r_frame_done;

    logic        w_sample;
    logic        w_advance;
    logic [1:0]  w_row_idx_nxt;
    logic [15:0] w_key_map;

    assign w_sample      = (r_cnt_slot == SCAN_MAX - 16'd1);
    assign w_advance     = (r_cnt_slot == SCAN_MAX);
    assign w_row_idx_nxt = r_row_idx + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= ~col;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_slot <= 16'd0;
            r_row_idx  <= 2'd0;
            r_row      <= 4'b1110;
        end else if (w_advance) begin
            r_cnt_slot <= 16'd0;
            r_row_idx  <= w_row_idx_nxt;
            r_row      <= ~(4'b0001 << w_row_idx_nxt);
        end else begin
            r_cnt_slot <= r_cnt_slot + 16'd1;
        end
    end

    // Sampling one clock before the row advance gives the columns the whole slot to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_buf  <= 16'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_sample && (r_row_idx == 2'd3);
            if (w_sample) begin
                r_frame_buf[{r_row_idx, 2'b00} +: 4] <= r_sync2;
            end
        end
    end

    key_frame_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .i_frame_done (r_frame_done),
        .i_frame      (r_frame_buf),
        .o_key_map    (w_key_map)
    );

    kms_state_t r_state;
    kms_state_t w_state_nxt;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_key_down;
    logic [3:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_down_nxt;
    logic       w_onehot;
    logic [3:0] w_idx;

    assign w_onehot = is_onehot16(w_key_map);
    assign w_idx    = onehot_idx16(w_key_map);

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        w_down_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = ST_HELD;
                    w_code_nxt  = w_idx;
                    w_valid_nxt = 1'b1;
                    w_down_nxt  = 1'b1;
                end else if (w_key_map != 16'd0) begin
                    w_state_nxt = ST_MULTI;
                end
            end
            ST_HELD: begin
                if (w_key_map == 16'd0) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_onehot) begin
                    w_state_nxt = ST_MULTI;
                end else begin
                    w_down_nxt = 1'b1;
                    // A different single key while held is a roll-over press.
                    if (w_idx != r_key_code) begin
                        w_code_nxt  = w_idx;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            ST_MULTI: begin
                if (w_key_map == 16'd0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_down  <= w_down_nxt;
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;
    assign key_map   = w_key_map;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: directed keypad scenarios plus random keypad
// phases checked against a press-level reference model.
module tb_key_matrix_scan;

    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] key_map;
    logic [15:0] keys = 16'd0;

    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its column low while its row is driven.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[4*r+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    key_matrix_scan #(
        .SCAN_MAX   (16'd9),
        .DEB_FRAMES (4'd3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .key_map   (key_map)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    int          pulse_cnt   = 0;
    int          map_changes = 0;
    int          down_low    = 0;
    logic [3:0]  pulse_codes[$];
    logic [15:0] prev_map    = 16'd0;

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt++;
            pulse_codes.push_back(key_code);
        end
        if (key_map != prev_map) map_changes++;
        prev_map = key_map;
        if (!key_down) down_low++;
    end

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    function automatic logic [31:0] last_code();
        if (pulse_codes.size() == 0) return 32'hDEAD;
        return 32'(pulse_codes[pulse_codes.size()-1]);
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_row"},   32'(row),       32'hE);
        chk({pfx, "_code"},  32'(key_code),  32'h0);
        chk({pfx, "_valid"}, 32'(key_valid), 32'h0);
        chk({pfx, "_down"},  32'(key_down),  32'h0);
        chk({pfx, "_map"},   32'(key_map),   32'h0);
    endtask

    int          p0, m0, d0;
    logic [3:0]  exp_row;
    logic        m_held, m_multi;
    logic [3:0]  m_code;
    logic [15:0] set;
    int          exp_pulse, nbits, k1, k2;
    logic [3:0]  idx;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b1;

        // 1: idle row walk, 10 clk per slot, wrapping after row 3.
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k % 10 == 5) begin
                exp_row = 4'b0001 << ((k / 10) % 4);
                exp_row = ~exp_row;
                chk($sformatf("t1_row_k%0d", k), 32'(row), 32'(exp_row));
            end
        end
        @(negedge clk);
        p0 = pulse_cnt; m0 = map_changes;
        frames(4);
        chk("t1_pulses", pulse_cnt - p0, 0);
        chk("t1_mapchg", map_changes - m0, 0);
        chk("t1_down", 32'(key_down), 0);

        // 2: single key (2,1).
        p0 = pulse_cnt;
        keys = 16'h0200;
        frames(8);
        chk("t2_pulses", pulse_cnt - p0, 1);
        chk("t2_pcode", last_code(), 9);
        chk("t2_code", 32'(key_code), 9);
        chk("t2_down", 32'(key_down), 1);
        chk("t2_map", 32'(key_map), 32'h0200);
        keys = 16'h0000;
        frames(4);
        chk("t2_rel_down", 32'(key_down), 0);
        chk("t2_rel_code", 32'(key_code), 9);
        chk("t2_rel_map", 32'(key_map), 0);
        frames(2);

        // 3: bouncing key (0,3), then steady.
        p0 = pulse_cnt; m0 = map_changes;
        keys = 16'h0008;
        for (int i = 0; i < 4; i++) begin
            repeat (35) @(negedge clk);
            keys = keys ^ 16'h0008;
        end
        repeat (20) @(negedge clk);
        chk("t3_bounce_pulses", pulse_cnt - p0, 0);
        chk("t3_bounce_mapchg", map_changes - m0, 0);
        frames(8);
        chk("t3_pulses", pulse_cnt - p0, 1);
        chk("t3_code", 32'(key_code), 3);
        keys = 16'h0000;
        frames(6);

        // 4: two keys together, partial release, then a fresh key.
        p0 = pulse_cnt;
        keys = 16'h0021;
        frames(8);
        chk("t4_map", 32'(key_map), 32'h0021);
        chk("t4_down", 32'(key_down), 0);
        chk("t4_pulses", pulse_cnt - p0, 0);
        keys = 16'h0001;
        frames(8);
        chk("t4_part_pulses", pulse_cnt - p0, 0);
        chk("t4_part_map", 32'(key_map), 32'h0001);
        chk("t4_part_down", 32'(key_down), 0);
        keys = 16'h0000;
        frames(8);
        chk("t4_rel_map", 32'(key_map), 0);
        keys = 16'h8000;
        frames(8);
        chk("t4_new_pulses", pulse_cnt - p0, 1);
        chk("t4_new_code", 32'(key_code), 15);
        keys = 16'h0000;
        frames(8);

        // 5: roll-over from (1,0) to (1,2).
        p0 = pulse_cnt;
        keys = 16'h0010;
        frames(8);
        chk("t5_first_pulses", pulse_cnt - p0, 1);
        chk("t5_first_code", last_code(), 4);
        d0 = down_low;
        keys = 16'h0050;
        repeat (3) @(negedge clk);
        keys = 16'h0040;
        frames(8);
        chk("t5_pulses", pulse_cnt - p0, 2);
        chk("t5_code", last_code(), 6);
        chk("t5_down_gaps", down_low - d0, 0);
        keys = 16'h0000;
        frames(8);

        // 6: reset while key (3,2) is held.
        keys = 16'h4000;
        frames(8);
        chk("t6_pre_code", 32'(key_code), 14);
        repeat (13) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        @(negedge clk);
        rst = 1'b1;
        p0 = pulse_cnt;
        frames(8);
        chk("t6_pulses", pulse_cnt - p0, 1);
        chk("t6_code", 32'(key_code), 14);
        keys = 16'h0000;
        frames(8);

        // Random keypad phases against the press-level model.
        m_held = 1'b0; m_multi = 1'b0; m_code = 4'd14;
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 3))
                0: set = 16'h0000;
                3: begin
                    k1 = int'($urandom_range(0, 15));
                    k2 = (k1 + int'($urandom_range(1, 15))) % 16;
                    set = (16'h1 << k1) | (16'h1 << k2);
                end
                default: set = 16'h1 << $urandom_range(0, 15);
            endcase
            p0 = pulse_cnt;
            keys = set;
            frames(7);
            nbits = $countones(set);
            exp_pulse = 0;
            if (nbits == 0) begin
                m_held = 1'b0; m_multi = 1'b0;
            end else if (nbits > 1) begin
                m_held = 1'b0; m_multi = 1'b1;
            end else if (!m_multi) begin
                for (int b = 0; b < 16; b++) if (set[b]) idx = 4'(b);
                if (!m_held || idx != m_code) begin
                    exp_pulse = 1;
                    m_code = idx;
                end
                m_held = 1'b1;
            end
            chk($sformatf("rnd%0d_pulses", t), pulse_cnt - p0, exp_pulse);
            chk($sformatf("rnd%0d_map", t), 32'(key_map), 32'(set));
            chk($sformatf("rnd%0d_down", t), 32'(key_down), 32'(m_held));
            chk($sformatf("rnd%0d_code", t), 32'(key_code), 32'(m_code));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
